// File: rtl/therm_pkg.sv
// Shared types and constants for the ring-oscillator thermometer sequencer.
package therm_pkg;

  // Measurement / frame sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    ACCUM   = 3'd3,
    SEND    = 3'd4,
    GAP     = 3'd5
  } seq_state_t;

  // Per-byte UART handshake states inside the frame serializer
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WFREE = 2'd1,  // UART still busy from elsewhere, hold off start
    TX_REQ   = 2'd2,  // uart_start high until busy is seen
    TX_DRAIN = 2'd3   // wait for busy to fall
  } tx_state_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // Frame byte positions, in transmit order
  localparam logic [1:0] IDX_HDR  = 2'd0;
  localparam logic [1:0] IDX_AVG  = 2'd1;
  localparam logic [1:0] IDX_STAT = 2'd2;
  localparam logic [1:0] IDX_CHK  = 2'd3;

  typedef struct packed {
    logic [7:0] hdr;
    logic [7:0] avg;
    logic [7:0] stat;
    logic [7:0] chk;
  } frame_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                           input logic [7:0] avg,
                                           input logic [7:0] stat);
    return hdr ^ avg ^ stat;
  endfunction

endpackage

// File: rtl/therm_meas_sequencer_if.sv
// Byte UART start/busy handshake between the sequencer and the transmitter.
interface therm_meas_sequencer_if;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       uart_busy;

  modport master (output uart_start, output uart_data, input uart_busy);
  modport slave  (input uart_start, input uart_data, output uart_busy);
endinterface

// File: rtl/therm_frame_tx.sv
// Serializes a registered 4-byte frame through the UART start/busy handshake.
module therm_frame_tx
  import therm_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   go,     // frame is being registered this cycle, start next
  input  frame_t frame,
  output logic   done,   // checksum byte's busy has fallen
  therm_meas_sequencer_if.master uart
);

  tx_state_t  state, state_nxt;
  logic [1:0] idx, idx_nxt;

  // State and byte index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TX_IDLE;
      idx   <= IDX_HDR;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Handshake sequencing; a busy UART at frame start defers uart_start
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done      = 1'b0;
    case (state)
      TX_IDLE: if (go) begin
        idx_nxt   = IDX_HDR;
        state_nxt = uart.uart_busy ? TX_WFREE : TX_REQ;
      end
      TX_WFREE: if (!uart.uart_busy) state_nxt = TX_REQ;
      TX_REQ:   if (uart.uart_busy)  state_nxt = TX_DRAIN;
      TX_DRAIN: if (!uart.uart_busy) begin
        if (idx == IDX_CHK) begin
          done      = 1'b1;
          state_nxt = TX_IDLE;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = TX_REQ;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Byte select; frame is registered so data is stable across the byte
  always_comb begin
    case (idx)
      IDX_HDR:  uart.uart_data = frame.hdr;
      IDX_AVG:  uart.uart_data = frame.avg;
      IDX_STAT: uart.uart_data = frame.stat;
      default:  uart.uart_data = frame.chk;
    endcase
  end

  assign uart.uart_start = (state == TX_REQ);

endmodule

// File: rtl/therm_meas_sequencer.sv
// Ring-oscillator thermometer sequencer: settle, windowed counting, averaging,
// hysteresis alarm, and hand-off of the 4-byte frame to the serializer.
module therm_meas_sequencer
  import therm_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 16,
  parameter int         AVG_LOG2      = 2,
  parameter int         GAP_CYCLES    = 1000,
  parameter logic [7:0] HDR_BYTE      = HDR_BYTE_DEF,
  parameter logic [7:0] ALARM_HI      = 8'd200,
  parameter logic [7:0] ALARM_LO      = 8'd50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       ro_en,
  output logic       win_start,
  input  logic       win_done,
  input  logic [7:0] win_count,
  therm_meas_sequencer_if.master uart,
  output logic [7:0] avg_out,
  output logic       alarm,
  output logic       frame_done
);

  localparam int ACC_W  = 8 + AVG_LOG2;
  localparam int NWIN   = 1 << AVG_LOG2;
  localparam int TMR_MX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int TMR_W  = $clog2(TMR_MX + 1);

  seq_state_t       state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [4:0]       win_idx;
  logic [4:0]       seq;
  frame_t           frame;
  logic             tx_done;

  logic             last_win;
  logic [7:0]       avg_c;
  logic             alarm_c;
  logic [7:0]       stat_c;

  assign last_win = (win_idx == 5'(NWIN - 1));
  assign avg_c    = acc[AVG_LOG2 +: 8];
  assign alarm_c  = (avg_c >= ALARM_HI) ? 1'b1 :
                    (avg_c <= ALARM_LO) ? 1'b0 : alarm;
  assign stat_c   = {alarm_c, sat, 1'b0, seq};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; run is only sampled at frame boundaries so frames never truncate
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = SETTLE;
      SETTLE:  if (tmr == '0) state_nxt = MEASURE;
      MEASURE: if (win_done && last_win) state_nxt = ACCUM;
      ACCUM:   state_nxt = SEND;
      SEND:    if (tx_done) state_nxt = GAP;
      GAP:     if (tmr == '0) state_nxt = run ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timers, accumulation, alarm and frame capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr       <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      win_idx   <= '0;
      seq       <= '0;
      win_start <= 1'b0;
      avg_out   <= '0;
      alarm     <= 1'b0;
      frame     <= '0;
    end else begin
      if (state_nxt == SETTLE && state != SETTLE)
        tmr <= TMR_W'(SETTLE_CYCLES - 1);
      else if (state_nxt == GAP && state != GAP)
        tmr <= TMR_W'(GAP_CYCLES - 1);
      else if (tmr != '0)
        tmr <= tmr - 1'b1;

      // Back-to-back windows within a burst skip the settle time
      win_start <= (state == SETTLE && tmr == '0) ||
                   (state == MEASURE && win_done && !last_win);

      if (state == MEASURE && win_done) begin
        acc     <= acc + ACC_W'(win_count);
        sat     <= sat | (win_count == 8'hFF);
        win_idx <= win_idx + 5'd1;
      end

      if (state == ACCUM) begin
        avg_out <= avg_c;
        alarm   <= alarm_c;
        frame   <= '{hdr:  HDR_BYTE,
                     avg:  avg_c,
                     stat: stat_c,
                     chk:  frame_chk(HDR_BYTE, avg_c, stat_c)};
      end

      if (state == SEND && tx_done) begin
        seq     <= seq + 5'd1;
        acc     <= '0;
        sat     <= 1'b0;
        win_idx <= '0;
      end
    end
  end

  assign ro_en      = (state == SETTLE) || (state == MEASURE);
  assign frame_done = tx_done;

  therm_frame_tx u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (state == ACCUM),
    .frame (frame),
    .done  (tx_done),
    .uart  (uart)
  );

endmodule

// File: tb/tb_therm_meas_sequencer.sv
// Directed + randomized bench with a frame-level reference model.
module tb_therm_meas_sequencer;

  localparam int SETTLE = 16;
  localparam int AVGL   = 2;
  localparam int GAPC   = 50;
  localparam int NW     = 1 << AVGL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       win_done = 1'b0;
  logic [7:0] win_count = 8'd0;
  logic       ro_en, win_start, alarm, frame_done;
  logic [7:0] avg_out;
  logic       busy_m = 1'b0;
  logic       busy_force = 1'b0;

  therm_meas_sequencer_if u ();
  assign u.uart_busy = busy_m | busy_force;

  therm_meas_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .AVG_LOG2      (AVGL),
    .GAP_CYCLES    (GAPC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .ro_en      (ro_en),
    .win_start  (win_start),
    .win_done   (win_done),
    .win_count  (win_count),
    .uart       (u),
    .avg_out    (avg_out),
    .alarm      (alarm),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int ws_cnt = 0;
  int wd_cnt = 0;
  int wd_cyc = 0;
  int fd_exp = 0;
  logic [7:0] cnt_q[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];

  // Reference model state
  logic       m_alarm = 1'b0;
  logic [4:0] m_seq = 5'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (win_start)  ws_cnt <= ws_cnt + 1;
  end

  // Window/latch model: answer each win_start with one win_done after a delay
  always begin : win_model
    int d;
    @(negedge clk);
    if (win_start && rst_n) begin
      d = $urandom_range(3, 10);
      repeat (d) @(posedge clk);
      #1;
      win_count = (cnt_q.size() > 0) ? cnt_q.pop_front() : 8'($urandom_range(0, 254));
      win_done  = 1'b1;
      wd_cnt++;
      wd_cyc = cyc;
      @(posedge clk); #1;
      win_done = 1'b0;
    end
  end

  // UART model: accept a byte on start, stay busy a random time
  always begin : uart_model
    int d;
    @(negedge clk);
    if (u.uart_start && !u.uart_busy) begin
      rx_q.push_back(u.uart_data);
      rx_cyc_q.push_back(cyc);
      @(posedge clk); #1;
      busy_m = 1'b1;
      d = $urandom_range(2, 6);
      repeat (d) @(posedge clk);
      #1;
      busy_m = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    cnt_q.push_back(8'(a));
    cnt_q.push_back(8'(b));
    cnt_q.push_back(8'(c));
    cnt_q.push_back(8'(d));
  endtask

  // Expected frame from the window counts: mean, saturation, hysteresis, sequence
  task automatic expect_frame(input string tag, input int c0, input int c1,
                              input int c2, input int c3, input bit lat);
    int         sum, t, hdr_cyc;
    logic [7:0] avg8, st;
    logic       sat;
    logic [7:0] exp_b [4];
    sum  = c0 + c1 + c2 + c3;
    avg8 = 8'(sum / NW);
    sat  = (c0 == 255) || (c1 == 255) || (c2 == 255) || (c3 == 255);
    if (avg8 >= 8'd200)     m_alarm = 1'b1;
    else if (avg8 <= 8'd50) m_alarm = 1'b0;
    st    = {m_alarm, sat, 1'b0, m_seq};
    exp_b = '{8'hA5, avg8, st, 8'hA5 ^ avg8 ^ st};
    t = 0;
    while (rx_q.size() < 4 && t < 3000) begin @(negedge clk); t++; end
    chk({tag, "_rx_timeout"}, 32'(rx_q.size() >= 4), 32'd1);
    if (rx_q.size() >= 4) begin
      hdr_cyc = rx_cyc_q[0];
      if (lat) chk({tag, "_latency"}, 32'(hdr_cyc - wd_cyc), 32'd2);
      chk({tag, "_hdr"},  32'(rx_q.pop_front()), 32'(exp_b[0]));
      chk({tag, "_avg"},  32'(rx_q.pop_front()), 32'(exp_b[1]));
      chk({tag, "_stat"}, 32'(rx_q.pop_front()), 32'(exp_b[2]));
      chk({tag, "_chk"},  32'(rx_q.pop_front()), 32'(exp_b[3]));
      repeat (4) void'(rx_cyc_q.pop_front());
    end
    t = 0;
    while (fd_cnt <= fd_exp && t < 200) begin @(negedge clk); t++; end
    fd_exp++;
    repeat (2) @(negedge clk);
    chk({tag, "_frame_done"}, 32'(fd_cnt), 32'(fd_exp));
    chk({tag, "_avg_out"},    32'(avg_out), 32'(avg8));
    chk({tag, "_alarm"},      32'(alarm), 32'(m_alarm));
    m_seq = m_seq + 5'd1;
  endtask

  initial begin : main
    int t, w0, ws0, ro_seen, st_seen;
    int r[4];

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_win_start", 32'(win_start), 0);
    chk("rst_uart_start", 32'(u.uart_start), 0);
    chk("rst_uart_data", 32'(u.uart_data), 0);
    chk("rst_avg_out", 32'(avg_out), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_win_start", 32'(ws_cnt), 0);
    chk("idle_ro_en", 32'(ro_en), 0);

    // Basic frame: A5 67 00 C2
    push4(100, 102, 104, 106);
    @(posedge clk); #1; run = 1'b1;
    expect_frame("t1", 100, 102, 104, 106, 1'b1);
    chk("t1_avg_const", 32'(avg_out), 32'h67);

    // Hysteresis: set, hold, clear
    push4(210, 210, 210, 210); expect_frame("t2_hi",  210, 210, 210, 210, 1'b1);
    push4(120, 120, 120, 120); expect_frame("t2_mid", 120, 120, 120, 120, 1'b1);
    push4(40, 40, 40, 40);     expect_frame("t2_lo",  40, 40, 40, 40, 1'b1);

    // Saturated window sets sat for one frame only
    push4(255, 10, 10, 10); expect_frame("t3_sat", 255, 10, 10, 10, 1'b1);
    push4(30, 31, 32, 33);  expect_frame("t3_nosat", 30, 31, 32, 33, 1'b1);

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) r[i] = $urandom_range(0, 255);
      push4(r[0], r[1], r[2], r[3]);
      expect_frame("rnd", r[0], r[1], r[2], r[3], 1'b1);
    end

    // run dropped mid-burst: frame still completes, then idle
    for (int i = 0; i < 4; i++) r[i] = $urandom_range(0, 254);
    push4(r[0], r[1], r[2], r[3]);
    w0 = wd_cnt; t = 0;
    while (wd_cnt == w0 && t < 2000) begin @(negedge clk); t++; end
    chk("t4_first_window", 32'(wd_cnt > w0), 1);
    @(posedge clk); #1; run = 1'b0;
    expect_frame("t4", r[0], r[1], r[2], r[3], 1'b1);
    repeat (GAPC + 10) @(negedge clk);
    ws0 = ws_cnt; ro_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ro_en) ro_seen++;
    end
    chk("t4_idle_ro_en", 32'(ro_seen), 0);
    chk("t4_idle_win_start", 32'(ws_cnt - ws0), 0);

    // UART busy at frame start: uart_start must wait for busy to fall
    push4(150, 160, 170, 180);
    @(posedge clk); #1; run = 1'b1;
    w0 = wd_cnt; t = 0;
    while (wd_cnt < w0 + 3 && t < 2000) begin @(negedge clk); t++; end
    @(posedge clk); #1; busy_force = 1'b1;
    st_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u.uart_start) st_seen++;
    end
    chk("t5_all_windows_done", 32'(wd_cnt - w0), 4);
    chk("t5_start_held_low", 32'(st_seen), 0);
    @(posedge clk); #1; busy_force = 1'b0;
    expect_frame("t5", 150, 160, 170, 180, 1'b0);

    // Reset during the status byte
    push4(60, 70, 80, 90);
    t = 0;
    while (rx_q.size() < 2 && t < 3000) begin @(negedge clk); t++; end
    t = 0;
    while (!(u.uart_start && rx_q.size() >= 2) && t < 200) begin @(negedge clk); t++; end
    chk("t6_reached_stat", 32'(u.uart_start), 1);
    #1; rst_n = 1'b0; #1;
    chk("t6_uart_start_async", 32'(u.uart_start), 0);
    chk("t6_ro_en_async", 32'(ro_en), 0);
    chk("t6_avg_out_rst", 32'(avg_out), 0);
    run = 1'b0;
    repeat (12) @(negedge clk);
    rx_q.delete(); rx_cyc_q.delete(); cnt_q.delete();
    m_seq = 5'd0; m_alarm = 1'b0; fd_exp = fd_cnt;
    @(posedge clk); #1; rst_n = 1'b1;
    push4(220, 230, 240, 250);
    @(posedge clk); #1; run = 1'b1;
    expect_frame("t6_after", 220, 230, 240, 250, 1'b1);
    @(posedge clk); #1; run = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
